// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between a client and the ALU issue controller.
// master = client side (issues requests, consumes responses); slave = controller side.
interface alu_issue_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_n;
   logic             rsp_z;
   logic             rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_n, rsp_z, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_n, rsp_z, rsp_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving a combinational ULA: one request in flight, op-dependent
// settle time, registered response with error reporting and sticky N/Z flags.
module alu_issue_ctrl #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 4,
   parameter int TAG_W      = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_ctrl_if.slave bus,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic [3:0]  alu_sel_o,
   input  logic [31:0] alu_r_i,
   input  logic        alu_nflag_i,
   input  logic        alu_zflag_i,
   output logic        flag_n_o,
   output logic        flag_z_o
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_LAST = 4'd6;
   localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;
   logic [3:0]       alu_sel_q, alu_sel_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_n_q, rsp_n_d;
   logic             rsp_z_q, rsp_z_d;
   logic             rsp_err_q, rsp_err_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_z_q, flag_z_d;
   logic             req_ok;

   // Illegal opcodes and divide-by-zero never reach the ULA.
   assign req_ok = (bus.req_op <= OP_LAST) &&
                   !((bus.req_op == OP_DIV) && (bus.req_b == 32'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rsp_data_q <= '0;
         rsp_tag_q  <= '0;
         rsp_n_q    <= 1'b0;
         rsp_z_q    <= 1'b0;
         rsp_err_q  <= 1'b0;
         flag_n_q   <= 1'b0;
         flag_z_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         rsp_data_q <= rsp_data_d;
         rsp_tag_q  <= rsp_tag_d;
         rsp_n_q    <= rsp_n_d;
         rsp_z_q    <= rsp_z_d;
         rsp_err_q  <= rsp_err_d;
         flag_n_q   <= flag_n_d;
         flag_z_q   <= flag_z_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      rsp_data_d = rsp_data_q;
      rsp_tag_d  = rsp_tag_q;
      rsp_n_d    = rsp_n_q;
      rsp_z_d    = rsp_z_q;
      rsp_err_d  = rsp_err_q;
      flag_n_d   = flag_n_q;
      flag_z_d   = flag_z_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               rsp_tag_d = bus.req_tag;
               if (req_ok) begin
                  alu_a_d   = bus.req_a;
                  alu_b_d   = bus.req_b;
                  alu_sel_d = bus.req_op;
                  cnt_d     = (bus.req_op == OP_MUL) ? MUL_CNT :
                              (bus.req_op == OP_DIV) ? DIV_CNT : 4'd0;
                  state_d   = S_EXEC;
               end else begin
                  rsp_data_d = '0;
                  rsp_n_d    = 1'b0;
                  rsp_z_d    = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d = alu_r_i;
               rsp_n_d    = alu_nflag_i;
               rsp_z_d    = alu_zflag_i;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               if (!rsp_err_q) begin
                  flag_n_d = rsp_n_q;
                  flag_z_d = rsp_z_q;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_tag   = rsp_tag_q;
   assign bus.rsp_n     = rsp_n_q;
   assign bus.rsp_z     = rsp_z_q;
   assign bus.rsp_err   = rsp_err_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign alu_sel_o     = alu_sel_q;
   assign flag_n_o      = flag_n_q;
   assign flag_z_o      = flag_z_q;

endmodule
